// File: rtl/sad_best_match.sv
// ---------------------------------------------------------------------------
// sad_best_match
//
// Sequences a motion-search run over N_CAND candidate block positions.
// For each candidate it pulses the sad datapath enable, waits for the
// datapath busy flag to rise and then fall, and samples the SAD result.
// It keeps the lowest SAD seen and the index of the candidate that
// produced it. If the datapath never acknowledges an enable, the run
// is aborted with a sticky error.
//
// Ports
//   clk_i       : clock, all logic on the rising edge
//   rst_i       : synchronous active-high reset
//   start_i     : start a run (sampled only while idle)
//   sad_i       : SAD result from the datapath
//   busy_i      : datapath busy flag
//   sad_enb_o   : one-cycle enable pulse to the datapath
//   cand_idx_o  : candidate currently being computed (0 when idle)
//   best_sad_o  : minimum SAD of the last run
//   best_idx_o  : candidate index that achieved best_sad_o
//   done_o      : one-cycle pulse when a run ends
//   err_o       : sticky, last run aborted by an enable timeout
//   busy_o      : high from accepted start through the done_o cycle
// ---------------------------------------------------------------------------
module sad_best_match #(
    parameter int N_CAND      = 16,
    parameter int IDX_W       = (N_CAND > 1) ? $clog2(N_CAND) : 1,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      sad_i,
    input  logic             busy_i,
    output logic             sad_enb_o,
    output logic [IDX_W-1:0] cand_idx_o,
    output logic [31:0]      best_sad_o,
    output logic [IDX_W-1:0] best_idx_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CAPTURE,
        S_FINISH
    } state_t;

    localparam int               TO_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);

    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  cand_idx_q, cand_idx_d;
    logic [31:0]       best_sad_q, best_sad_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              err_q,      err_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cand_idx_q <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cand_idx_q <= cand_idx_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal gets a hold value first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        cand_idx_d = cand_idx_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_LAUNCH;
                    cand_idx_d = '0;
                    best_sad_d = '1;
                    best_idx_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // The counter is checked before incrementing, so WAIT_HI lasts
                // ACK_TIMEOUT+1 cycles when busy_i never rises.
                if (busy_i) begin
                    state_d = S_WAIT_LO;
                end else if (to_cnt_q == TO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!busy_i) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Strict compare: a tie keeps the earlier candidate.
                if (sad_i < best_sad_q) begin
                    best_sad_d = sad_i;
                    best_idx_d = cand_idx_q;
                end
                if (cand_idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    cand_idx_d = cand_idx_q + IDX_W'(1);
                    state_d    = S_LAUNCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        sad_enb_o  = (state_q == S_LAUNCH);
        done_o     = (state_q == S_FINISH);
        busy_o     = (state_q != S_IDLE);
        cand_idx_o = (state_q == S_IDLE) ? '0 : cand_idx_q;
        best_sad_o = best_sad_q;
        best_idx_o = best_idx_q;
        err_o      = err_q;
    end

endmodule

// File: tb/tb_sad_best_match.sv
// ---------------------------------------------------------------------------
// tb_sad_best_match
//
// Bench for sad_best_match with N_CAND=4, ACK_TIMEOUT=8. A behavioural sad
// datapath model answers each enable pulse from a queue of responses. The
// stimulus pushes the expected run result into a scoreboard queue; a monitor
// pops and compares whenever done_o pulses.
// ---------------------------------------------------------------------------
module tb_sad_best_match;

    localparam int N_CAND      = 4;
    localparam int IDX_W       = 2;
    localparam int ACK_TIMEOUT = 8;

    logic             clk;
    logic             rst_i;
    logic             start_i;
    logic [31:0]      sad_i;
    logic             busy_i;
    logic             sad_enb_o;
    logic [IDX_W-1:0] cand_idx_o;
    logic [31:0]      best_sad_o;
    logic [IDX_W-1:0] best_idx_o;
    logic             done_o;
    logic             err_o;
    logic             busy_o;

    sad_best_match #(
        .N_CAND      (N_CAND),
        .IDX_W       (IDX_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .sad_i      (sad_i),
        .busy_i     (busy_i),
        .sad_enb_o  (sad_enb_o),
        .cand_idx_o (cand_idx_o),
        .best_sad_o (best_sad_o),
        .best_idx_o (best_idx_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One datapath response: busy rises `rise` cycles after the enable is
    // seen, stays high `len` cycles, then drops with `val` on sad_i.
    typedef struct {
        logic [31:0] val;
        int          rise;
        int          len;
        bit          no_ack;
    } resp_t;

    // Expected run outcome; lat < 0 means done latency is not checked.
    typedef struct {
        logic [31:0] sad;
        logic [31:0] idx;
        bit          err;
        int          n_enb;
        int          lat;
    } exp_t;

    resp_t resp_q[$];
    exp_t  exp_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int enb_total  = 0;
    int done_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_resp(input logic [31:0] val, input int rise, input int len, input bit no_ack);
        resp_t r;
        r.val = val; r.rise = rise; r.len = len; r.no_ack = no_ack;
        resp_q.push_back(r);
    endtask

    task automatic push_exp(input logic [31:0] sad, input logic [31:0] idx, input bit err,
                            input int n_enb, input int lat);
        exp_t e;
        e.sad = sad; e.idx = idx; e.err = err; e.n_enb = n_enb; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // ---------------- sad datapath model ----------------
    initial begin : sad_model
        resp_t r;
        busy_i = 1'b0;
        sad_i  = 32'd0;
        forever begin
            @(negedge clk);
            if (sad_enb_o && !rst_i) begin
                if (resp_q.size() == 0) begin
                    check("model_resp_available", 32'(resp_q.size()), 32'd1);
                end else begin
                    r = resp_q.pop_front();
                    if (!r.no_ack) begin
                        for (int t = 0; t < r.rise + r.len; t++) begin
                            if (t == r.rise) busy_i = 1'b1;
                            @(negedge clk);
                            if (rst_i) break;
                        end
                        sad_i  = r.val;
                        busy_i = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int   cyc = 0;
        int   run_enb = 0;
        int   first_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_i) begin
                run_enb = 0;
            end else begin
                if (sad_enb_o) begin
                    if (run_enb == 0) begin
                        first_cyc = cyc;
                        check("start_err_cleared", 32'(err_o), 32'd0);
                        check("start_best_sad_init", best_sad_o, 32'hFFFF_FFFF);
                    end
                    check("enb_cand_idx", 32'(cand_idx_o), 32'(run_enb));
                    run_enb++;
                    enb_total++;
                end
                if (done_o) begin
                    done_total++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("best_sad", best_sad_o, e.sad);
                        check("best_idx", 32'(best_idx_o), e.idx);
                        check("err", 32'(err_o), 32'(e.err));
                        check("enables_per_run", 32'(run_enb), 32'(e.n_enb));
                        check("busy_in_done_cycle", 32'(busy_o), 32'd1);
                        if (e.lat >= 0) check("done_latency", 32'(cyc - first_cyc), 32'(e.lat));
                    end
                    run_enb = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_pulse();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("done_within_budget", 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enb"},      32'(sad_enb_o),  32'd0);
        check({tag, "_cand"},     32'(cand_idx_o), 32'd0);
        check({tag, "_best_sad"}, best_sad_o,      32'hFFFF_FFFF);
        check({tag, "_best_idx"}, 32'(best_idx_o), 32'd0);
        check({tag, "_done"},     32'(done_o),     32'd0);
        check({tag, "_err"},      32'(err_o),      32'd0);
        check({tag, "_busy"},     32'(busy_o),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bit seen;
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_i = 1'b0;

        // Reset then idle: outputs at reset values, no enable.
        @(negedge clk);
        check_reset_outputs("reset");
        repeat (10) @(negedge clk);
        check("idle_no_enable", 32'(enb_total), 32'd0);

        // Normal run, tie on 300 keeps index 1.
        push_resp(32'd500, 1, 10, 1'b0);
        push_resp(32'd300, 1, 10, 1'b0);
        push_resp(32'd300, 1, 10, 1'b0);
        push_resp(32'd900, 1, 10, 1'b0);
        push_exp(32'd300, 32'd1, 1'b0, 4, -1);
        start_pulse();
        wait_done(200);

        // Datapath never acknowledges: timeout on the first candidate.
        push_resp(32'd0, 0, 0, 1'b1);
        push_exp(32'hFFFF_FFFF, 32'd0, 1'b1, 1, ACK_TIMEOUT + 2);
        start_pulse();
        wait_done(100);
        repeat (3) @(negedge clk);
        check("err_sticky_idle", 32'(err_o), 32'd1);

        // Timeout on candidate 2 after results 70, 40.
        push_resp(32'd70, 0, 3, 1'b0);
        push_resp(32'd40, 2, 1, 1'b0);
        push_resp(32'd0,  0, 0, 1'b1);
        push_exp(32'd40, 32'd1, 1'b1, 3, -1);
        start_pulse();
        wait_done(200);

        // Reset during WAIT_LO of candidate 2: results 10, 20 must be lost.
        push_resp(32'd10, 1, 4, 1'b0);
        push_resp(32'd20, 1, 4, 1'b0);
        push_resp(32'd30, 1, 12, 1'b0);
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cand_idx_o == 2'd2 && busy_i) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_cand2_busy", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        #1 rst_i = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 32'(done_total), 32'd3);

        // Normal run after the aborted one.
        push_resp(32'd5, 0, 2, 1'b0);
        push_resp(32'd5, 1, 3, 1'b0);
        push_resp(32'd3, 2, 1, 1'b0);
        push_resp(32'd3, 0, 5, 1'b0);
        push_exp(32'd3, 32'd2, 1'b0, 4, -1);
        start_pulse();
        wait_done(200);

        // start_i held high: a timeout run then a clean run back-to-back;
        // err_o must clear at the second start.
        push_resp(32'd0, 0, 0, 1'b1);
        push_exp(32'hFFFF_FFFF, 32'd0, 1'b1, 1, ACK_TIMEOUT + 2);
        push_resp(32'd9, 1, 2, 1'b0);
        push_resp(32'd8, 1, 2, 1'b0);
        push_resp(32'd7, 1, 2, 1'b0);
        push_resp(32'd6, 1, 2, 1'b0);
        push_exp(32'd6, 32'd3, 1'b0, 4, -1);
        @(negedge clk);
        start_i = 1'b1;
        wait_done(100);
        wait_done(200);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_after_held_start", 32'(busy_o), 32'd0);

        check("runs_completed", 32'(done_total), 32'd6);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("responses_drained", 32'(resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Downstream consumer of the sad datapath; sequences a motion-search run over N_CAND candidate block positions.
- For each candidate it pulses the sad enable, waits for busy to rise and then fall, captures dt_o, and tracks the minimum SAD and its candidate index.
- Reports the best match, or a timeout error, once all candidates are processed.

Parameters:
- N_CAND, 16, number of candidate positions per run (>=1)
- IDX_W, $clog2(N_CAND) (min 1), width of candidate index
- ACK_TIMEOUT, 8, max cycles from enable pulse to busy_i rising before error

Ports:
- clk_i  input  1  clock, all logic rising-edge
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  start a run; sampled only in IDLE
- sad_i  input  32  SAD result from sad dt_o
- busy_i  input  1  sad busy_o
- sad_enb_o  output  1  one-cycle enable pulse to sad enb_i
- cand_idx_o  output  IDX_W  index of candidate currently being computed (drives upstream address gen)
- best_sad_o  output  32  minimum SAD of last run
- best_idx_o  output  IDX_W  index achieving best_sad_o
- done_o  output  1  one-cycle pulse when run ends
- err_o  output  1  sticky: last run aborted by timeout; cleared on next accepted start
- busy_o  output  1  high from accepted start until done_o cycle inclusive

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; all outputs 0, except best_sad_o=32'hFFFF_FFFF.
  - Reset has priority over every other event, including mid-run. sad_enb_o drops the next cycle, and no done_o is generated for the aborted run.
- FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO, CAPTURE, FINISH.
- IDLE:
  - On start_i=1: go to LAUNCH; cand_idx=0; best_sad=FFFF_FFFF; best_idx=0; err=0; busy_o=1.
  - start_i in any other state is ignored.
- LAUNCH: sad_enb_o=1 for exactly this cycle; timeout counter cleared; go to WAIT_HI.
- WAIT_HI:
  - busy_i=1: go to WAIT_LO.
  - Otherwise increment the timeout counter. If the counter reaches ACK_TIMEOUT, set err=1 and go to FINISH; best_sad/best_idx keep the values of completed candidates.
- WAIT_LO: remain while busy_i=1, with no timeout; busy_i=0 goes to CAPTURE.
- CAPTURE (sad_i sampled this cycle):
  - If sad_i < best_sad (unsigned, strict), update best_sad=sad_i and best_idx=cand_idx. Ties keep the earlier (lower) index.
  - If cand_idx==N_CAND-1, go to FINISH. Otherwise increment cand_idx and go to LAUNCH.
- FINISH: done_o=1 for one cycle; busy_o=1 in this cycle; go to IDLE.
- best_sad_o, best_idx_o, err_o hold until the next accepted start.
- Per-candidate latency: 1 (LAUNCH) + 1 + busy-rise delay + sad busy duration + 1 (CAPTURE) cycles.
- Back-to-back runs: start_i=1 in the cycle after done_o is accepted. The next start's earliest LAUNCH is 2 cycles after the FINISH cycle.
- cand_idx_o stable from LAUNCH through CAPTURE of that candidate; 0 when idle.
- If sad_i is exactly FFFF_FFFF on every candidate, best_sad stays FFFF_FFFF and best_idx=0.

Test Plan:
- Reset then idle -> best_sad_o=FFFF_FFFF, all other outputs 0, sad_enb_o never asserts.
- N_CAND=4, sad model returns 500,300,300,900 (busy 10 cycles each) -> 4 enable pulses, cand_idx_o 0..3, done_o once, best_sad_o=300, best_idx_o=1 (tie keeps lower), err_o=0.
- Sad model never raises busy -> err_o=1 and done_o pulse ACK_TIMEOUT+2 cycles after the first enable; best_sad_o=FFFF_FFFF.
- Timeout on candidate 2 after results 70,40 -> err_o=1, best_sad_o=40, best_idx_o=1.
- rst_i asserted during WAIT_LO of candidate 2 -> next cycle all outputs at reset values, no done_o; subsequent start runs normally.
- start_i held high continuously -> back-to-back runs, each with exactly N_CAND enables; err_o cleared at each new start; start pulses mid-run have no effect.
